// File: rtl/streamer_pkg.sv
// Shared types and default widths for the sample streamer.
package streamer_pkg;

  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned DATA_W_DEF = 23;
  localparam int unsigned OUT_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REQ = 2'd1,
    FETCH    = 2'd2,
    LATCH    = 2'd3
  } streamer_state_t;

endpackage

// File: rtl/streamer_addr_gen.sv
// ROM address window generator: holds start/end copies, steps the address,
// wraps modulo 2^ADDR_W and flags the last address of the window.
module streamer_addr_gen
  import streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              at_end
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_start;
  logic [ADDR_W-1:0] r_end;
  logic              w_at_end;

  assign w_at_end = (r_addr == r_end);
  assign at_end   = w_at_end;
  assign addr     = r_addr;

  // One-shot end holds the address; loop end jumps back to the start copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_start <= '0;
      r_end   <= '0;
    end else if (load) begin
      r_addr  <= start_addr;
      r_start <= start_addr;
      r_end   <= end_addr;
    end else if (advance) begin
      if (w_at_end) begin
        if (loop_en) r_addr <= r_start;
      end else begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sample_streamer.sv
// Paced ROM sample streamer feeding the IIR chain.
// Define SAMPLE_STREAMER_SIGNED_EN to sign-extend ROM words instead of zero-extending.
module sample_streamer
  import streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_req,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [OUT_W-1:0]  sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  streamer_state_t  r_state;
  logic [OUT_W-1:0] r_sample_out;
  logic             r_sample_valid;
  logic             r_done;
  logic             r_overrun;
  logic [OUT_W-1:0] w_ext;
  logic             w_load;
  logic             w_advance;
  logic             w_at_end;

  assign w_load    = (r_state == IDLE) && start && !stop;
  assign w_advance = (r_state == LATCH) && !stop;

`ifdef SAMPLE_STREAMER_SIGNED_EN
  assign w_ext = OUT_W'($signed(rom_q));
`else
  assign w_ext = OUT_W'(rom_q);
`endif

  streamer_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .advance    (w_advance),
    .loop_en    (loop_en),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .addr       (rom_addr),
    .at_end     (w_at_end)
  );

  // Playback FSM; stop pre-empts every other event in non-idle states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            r_overrun <= 1'b0;
            r_state   <= WAIT_REQ;
          end
        end
        WAIT_REQ: begin
          if (stop)            r_state <= IDLE;
          else if (sample_req) r_state <= FETCH;
        end
        FETCH: begin
          if (stop) begin
            r_state <= IDLE;
          end else begin
            if (sample_req) r_overrun <= 1'b1;
            r_state <= LATCH;
          end
        end
        LATCH: begin
          if (stop) begin
            r_state <= IDLE;
          end else begin
            r_sample_out   <= w_ext;
            r_sample_valid <= 1'b1;
            if (sample_req) r_overrun <= 1'b1;
            if (w_at_end && !loop_en) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_state <= WAIT_REQ;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = (r_state != IDLE);
  assign sample_out   = r_sample_out;
  assign sample_valid = r_sample_valid;
  assign done         = r_done;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sample_streamer.sv
// Directed bench for sample_streamer with a behavioural synchronous ROM.
module tb_sample_streamer;

  logic        clk;
  logic        rst;
  logic        sample_req;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [14:0] start_addr;
  logic [14:0] end_addr;
  logic [14:0] rom_addr;
  logic [22:0] rom_q;
  logic [31:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        done;
  logic        overrun;

  logic [22:0] rom [32768];
  int          n_tests;
  int          n_fail;
  int          n_valid;
  logic [31:0] exp_ext;

  sample_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_req   (sample_req),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [14:0] s, input logic [14:0] e);
    start      = 1'b1;
    start_addr = s;
    end_addr   = e;
    tick();
    start      = 1'b0;
  endtask

  // One request, checked for exactly two clocks of latency, then idle gap.
  task automatic do_req(input string tag, input logic [31:0] exp_data, input logic exp_done);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    check({tag, "_v_fetch"}, 64'(sample_valid), 64'd0);
    tick();
    check({tag, "_v_latch"}, 64'(sample_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(sample_valid), 64'd1);
    check({tag, "_data"}, 64'(sample_out), 64'(exp_data));
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    repeat (7) tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    sample_req = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    start_addr = '0; end_addr = '0; rst = 1'b1;
    for (int i = 0; i < 32768; i++) rom[i] = 23'(i + 5);
    rom[20] = 23'h400000;

    // Reset state
    #2 rst = 1'b0;
    #10;
    check("rst_addr",    64'(rom_addr),     64'd0);
    check("rst_out",     64'(sample_out),   64'd0);
    check("rst_valid",   64'(sample_valid), 64'd0);
    check("rst_busy",    64'(busy),         64'd0);
    check("rst_done",    64'(done),         64'd0);
    check("rst_overrun", 64'(overrun),      64'd0);
    #10 rst = 1'b1;
    tick();

    // stop beats start in IDLE
    start = 1'b1; stop = 1'b1; start_addr = 15'd5; end_addr = 15'd6;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 64'(busy),     64'd0);
    check("ss_addr", 64'(rom_addr), 64'd0);

    // One-shot 0..3
    loop_en = 1'b0;
    do_start(15'd0, 15'd3);
    check("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), 64'(rom_addr), 64'(i));
      do_req($sformatf("t1_%0d", i), 32'(i + 5), (i == 3));
    end
    check("t1_busy_end", 64'(busy),     64'd0);
    check("t1_addr_end", 64'(rom_addr), 64'd3);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    n_valid = 0;
    repeat (4) begin
      n_valid += int'(sample_valid);
      tick();
    end
    check("t1_idle_req_valid",   64'(n_valid), 64'd0);
    check("t1_idle_req_overrun", 64'(overrun), 64'd0);

    // Loop 10..11; a start while busy is ignored
    loop_en = 1'b1;
    do_start(15'd10, 15'd11);
    do_req("t2_0", 32'd15, 1'b0);
    start = 1'b1; start_addr = 15'd0; end_addr = 15'd0;
    tick();
    start = 1'b0;
    do_req("t2_1", 32'd16, 1'b0);
    do_req("t2_2", 32'd15, 1'b0);
    do_req("t2_3", 32'd16, 1'b0);
    do_req("t2_4", 32'd15, 1'b0);
    check("t2_addr", 64'(rom_addr), 64'd11);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t2_stop_busy", 64'(busy),       64'd0);
    check("t2_stop_hold", 64'(sample_out), 64'd15);

    // Window wrapping through the top of the address space
    loop_en = 1'b0;
    do_start(15'h7FFE, 15'h0001);
    check("t3_a0", 64'(rom_addr), 64'h7FFE);
    do_req("t3_0", 32'h8003, 1'b0);
    check("t3_a1", 64'(rom_addr), 64'h7FFF);
    do_req("t3_1", 32'h8004, 1'b0);
    check("t3_a2", 64'(rom_addr), 64'h0000);
    do_req("t3_2", 32'd5, 1'b0);
    check("t3_a3", 64'(rom_addr), 64'h0001);
    do_req("t3_3", 32'd6, 1'b1);
    check("t3_busy", 64'(busy), 64'd0);

    // Back-to-back requests: one valid, sticky overrun
    do_start(15'd0, 15'd3);
    sample_req = 1'b1;
    tick();
    tick();
    sample_req = 1'b0;
    n_valid = 0;
    repeat (6) begin
      n_valid += int'(sample_valid);
      if (sample_valid) check("t4_data", 64'(sample_out), 64'd5);
      tick();
    end
    check("t4_nvalid",  64'(n_valid), 64'd1);
    check("t4_overrun", 64'(overrun), 64'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_ovr_after_stop", 64'(overrun), 64'd1);
    do_start(15'd0, 15'd3);
    check("t4_ovr_cleared", 64'(overrun), 64'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Extension of a word with the top data bit set
`ifdef SAMPLE_STREAMER_SIGNED_EN
    exp_ext = 32'hFFC00000;
`else
    exp_ext = 32'h00400000;
`endif
    do_start(15'd20, 15'd20);
    do_req("t5_ext", exp_ext, 1'b1);

    // Async reset between FETCH and LATCH
    do_start(15'd1, 15'd3);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    check("t6_busy_fetch", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("t6_addr",    64'(rom_addr),     64'd0);
    check("t6_out",     64'(sample_out),   64'd0);
    check("t6_valid",   64'(sample_valid), 64'd0);
    check("t6_busy",    64'(busy),         64'd0);
    check("t6_done",    64'(done),         64'd0);
    check("t6_overrun", 64'(overrun),      64'd0);
    #10 rst = 1'b1;
    n_valid = 0;
    repeat (5) begin
      tick();
      n_valid += int'(sample_valid);
    end
    check("t6_no_valid", 64'(n_valid), 64'd0);
    check("t6_idle",     64'(busy),    64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
